// File: rtl/ef_psram_slave_model.sv
`default_nettype none
// ============================================================================
// Module   : ef_psram_slave_model
// Brief    : SPI/QPI PSRAM slave that oversamples sck/ce_n/din on HCLK and
//            serves reads/writes from an internal byte array.
// Revision : 1.0 - initial release
// ============================================================================
module ef_psram_slave_model #(
    parameter int MEM_AW      = 10,
    parameter int WAIT_CYCLES = 6
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       sck,
    input  logic       ce_n,
    input  logic [3:0] din,
    output logic [3:0] dout,
    output logic [3:0] douten,
    output logic       qpi_mode
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMD   = 3'd1,
        S_ADDR  = 3'd2,
        S_WAIT  = 3'd3,
        S_RDATA = 3'd4,
        S_WDATA = 3'd5,
        S_DROP  = 3'd6
    } state_t;

    localparam logic [7:0] c_wait_last = 8'(WAIT_CYCLES - 1);
    localparam int         c_mem_depth = 2 ** MEM_AW;

    // [0]/[1] are the synchroniser, [2] the previous synchronised value
    logic [2:0] r_sck_s;
    logic [2:0] r_ce_s;
    logic [3:0] r_din_m;
    logic [3:0] r_din_s;

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [6:0]  r_shift;
    logic [23:0] r_addr;
    logic [6:0]  r_wbyte;
    logic        r_quad;
    logic        r_read;
    logic        r_dummy;
    logic        r_qpi;
    logic        r_pend_set;
    logic        r_pend_clr;
    logic [3:0]  r_dout;
    logic [3:0]  r_douten;
    logic [7:0]  r_rdata;
    logic [7:0]  r_mem [c_mem_depth];

    state_t      w_state_nxt;
    logic [7:0]  w_cnt_nxt;
    logic [6:0]  w_shift_nxt;
    logic [23:0] w_addr_nxt;
    logic [6:0]  w_wbyte_nxt;
    logic        w_quad_nxt;
    logic        w_read_nxt;
    logic        w_dummy_nxt;
    logic        w_qpi_nxt;
    logic        w_pend_set_nxt;
    logic        w_pend_clr_nxt;
    logic [3:0]  w_dout_nxt;
    logic [3:0]  w_douten_nxt;
    logic        w_mem_we;

    logic        w_sck_rise;
    logic        w_sck_fall;
    logic        w_ce_rise;
    logic        w_ce_fall;
    logic [7:0]  w_cmd;
    logic [23:0] w_addr_in;
    logic [7:0]  w_wbyte_in;
    logic        w_unit_last;
    logic        w_addr_last;

    // ce_n flops reset low so a ce_n held low across reset release never looks like a fall
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_sck_s <= '0;
            r_ce_s  <= '0;
            r_din_m <= '0;
            r_din_s <= '0;
        end else begin
            r_sck_s <= {r_sck_s[1:0], sck};
            r_ce_s  <= {r_ce_s[1:0], ce_n};
            r_din_m <= din;
            r_din_s <= r_din_m;
        end
    end

    assign w_sck_rise  =  r_sck_s[1] & ~r_sck_s[2];
    assign w_sck_fall  = ~r_sck_s[1] &  r_sck_s[2];
    assign w_ce_rise   =  r_ce_s[1]  & ~r_ce_s[2];
    assign w_ce_fall   = ~r_ce_s[1]  &  r_ce_s[2];

    assign w_cmd       = r_quad ? {r_shift[3:0], r_din_s} : {r_shift, r_din_s[0]};
    assign w_addr_in   = r_quad ? {r_addr[19:0], r_din_s} : {r_addr[22:0], r_din_s[0]};
    assign w_wbyte_in  = r_quad ? {r_wbyte[3:0], r_din_s} : {r_wbyte, r_din_s[0]};
    assign w_unit_last = r_quad ? (r_cnt == 8'd1) : (r_cnt == 8'd7);
    assign w_addr_last = r_quad ? (r_cnt == 8'd5) : (r_cnt == 8'd23);

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_shift_nxt    = r_shift;
        w_addr_nxt     = r_addr;
        w_wbyte_nxt    = r_wbyte;
        w_quad_nxt     = r_quad;
        w_read_nxt     = r_read;
        w_dummy_nxt    = r_dummy;
        w_qpi_nxt      = r_qpi;
        w_pend_set_nxt = r_pend_set;
        w_pend_clr_nxt = r_pend_clr;
        w_dout_nxt     = r_dout;
        w_douten_nxt   = r_douten;
        w_mem_we       = 1'b0;

        if (w_ce_rise) begin
            w_state_nxt    = S_IDLE;
            w_cnt_nxt      = '0;
            w_pend_set_nxt = 1'b0;
            w_pend_clr_nxt = 1'b0;
            if (r_pend_set) w_qpi_nxt = 1'b1;
            if (r_pend_clr) w_qpi_nxt = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_ce_fall) begin
                        w_state_nxt = S_CMD;
                        w_cnt_nxt   = '0;
                        w_quad_nxt  = r_qpi;
                    end
                end
                S_CMD: begin
                    if (w_sck_rise) begin
                        w_shift_nxt = w_cmd[6:0];
                        w_cnt_nxt   = r_cnt + 8'd1;
                        if (w_unit_last) begin
                            w_cnt_nxt   = '0;
                            w_state_nxt = S_DROP;
                            case (w_cmd)
                                8'h03, 8'h02: begin
                                    w_state_nxt = S_ADDR;
                                    w_read_nxt  = (w_cmd == 8'h03);
                                    w_quad_nxt  = r_qpi;
                                    w_dummy_nxt = r_qpi;
                                end
                                8'hEB, 8'h38: begin
                                    w_state_nxt = S_ADDR;
                                    w_read_nxt  = (w_cmd == 8'hEB);
                                    w_quad_nxt  = 1'b1;
                                    w_dummy_nxt = 1'b1;
                                end
                                8'h35:   w_pend_set_nxt = ~r_qpi;
                                8'hF5:   w_pend_clr_nxt = r_qpi;
                                default: ;
                            endcase
                        end
                    end
                end
                S_ADDR: begin
                    if (w_sck_rise) begin
                        w_addr_nxt = w_addr_in;
                        w_cnt_nxt  = r_cnt + 8'd1;
                        if (w_addr_last) begin
                            w_cnt_nxt = '0;
                            if (!r_read)
                                w_state_nxt = S_WDATA;
                            else if (r_dummy && (WAIT_CYCLES != 0))
                                w_state_nxt = S_WAIT;
                            else
                                w_state_nxt = S_RDATA;
                        end
                    end
                end
                S_WAIT: begin
                    if (w_sck_rise) begin
                        w_cnt_nxt = r_cnt + 8'd1;
                        if (r_cnt == c_wait_last) begin
                            w_cnt_nxt   = '0;
                            w_state_nxt = S_RDATA;
                        end
                    end
                end
                S_RDATA: begin
                    // the byte at r_addr is already in r_rdata; the fall launches the next beat
                    if (w_sck_fall) begin
                        if (r_quad) begin
                            w_dout_nxt   = r_cnt[0] ? r_rdata[3:0] : r_rdata[7:4];
                            w_douten_nxt = 4'b1111;
                        end else begin
                            w_dout_nxt   = {2'b00, r_rdata[3'd7 - r_cnt[2:0]], 1'b0};
                            w_douten_nxt = 4'b0010;
                        end
                        w_cnt_nxt = r_cnt + 8'd1;
                        if (w_unit_last) begin
                            w_cnt_nxt  = '0;
                            w_addr_nxt = r_addr + 24'd1;
                        end
                    end
                end
                S_WDATA: begin
                    if (w_sck_rise) begin
                        w_wbyte_nxt = w_wbyte_in[6:0];
                        w_cnt_nxt   = r_cnt + 8'd1;
                        if (w_unit_last) begin
                            w_mem_we   = 1'b1;
                            w_cnt_nxt  = '0;
                            w_addr_nxt = r_addr + 24'd1;
                        end
                    end
                end
                default: ;
            endcase
        end

        if (w_state_nxt != S_RDATA) begin
            w_dout_nxt   = '0;
            w_douten_nxt = '0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_shift    <= '0;
            r_addr     <= '0;
            r_wbyte    <= '0;
            r_quad     <= 1'b0;
            r_read     <= 1'b0;
            r_dummy    <= 1'b0;
            r_qpi      <= 1'b0;
            r_pend_set <= 1'b0;
            r_pend_clr <= 1'b0;
            r_dout     <= '0;
            r_douten   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_addr     <= w_addr_nxt;
            r_wbyte    <= w_wbyte_nxt;
            r_quad     <= w_quad_nxt;
            r_read     <= w_read_nxt;
            r_dummy    <= w_dummy_nxt;
            r_qpi      <= w_qpi_nxt;
            r_pend_set <= w_pend_set_nxt;
            r_pend_clr <= w_pend_clr_nxt;
            r_dout     <= w_dout_nxt;
            r_douten   <= w_douten_nxt;
        end
    end

    // storage is deliberately outside the reset domain so contents survive HRESETn
    always_ff @(posedge HCLK) begin
        if (w_mem_we)
            r_mem[r_addr[MEM_AW-1:0]] <= w_wbyte_in;
        r_rdata <= r_mem[r_addr[MEM_AW-1:0]];
    end

    assign dout     = r_dout;
    assign douten   = r_douten;
    assign qpi_mode = r_qpi;

endmodule
`default_nettype wire

// File: tb/tb_ef_psram_slave_model.sv
`default_nettype none
// ============================================================================
// Module   : tb_ef_psram_slave_model
// Brief    : Scoreboard bench for ef_psram_slave_model with a byte-array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ef_psram_slave_model;

    localparam int MEM_AW      = 10;
    localparam int WAIT_CYCLES = 6;
    localparam int DEPTH       = 1 << MEM_AW;
    localparam int HALF        = 60;

    logic       HCLK = 1'b0;
    logic       HRESETn;
    logic       sck;
    logic       ce_n;
    logic [3:0] din;
    logic [3:0] dout;
    logic [3:0] douten;
    logic       qpi_mode;

    ef_psram_slave_model #(
        .MEM_AW      (MEM_AW),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_dut (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .sck      (sck),
        .ce_n     (ce_n),
        .din      (din),
        .dout     (dout),
        .douten   (douten),
        .qpi_mode (qpi_mode)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [7:0] v;
        bit         care;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] m_mem   [DEPTH];
    bit         m_known [DEPTH];
    bit         m_qpi;
    int         n_tests  = 0;
    int         n_fail   = 0;
    int         rd_phase = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // monitor: the controller samples dout on each sck rise
    logic [7:0] mon_acc  = '0;
    int         mon_bits = 0;
    exp_t       mon_e;
    always @(posedge sck) begin
        if (rd_phase == 0) begin
            mon_bits = 0;
            chk("douten_idle", 32'(douten), 32'h0);
        end else begin
            chk("douten_data", 32'(douten), (rd_phase == 2) ? 32'hF : 32'h2);
            if (rd_phase == 2) begin
                mon_acc  = {mon_acc[3:0], dout};
                mon_bits += 4;
            end else begin
                mon_acc  = {mon_acc[6:0], dout[1]};
                mon_bits += 1;
            end
            if (mon_bits == 8) begin
                mon_bits = 0;
                chk("expect_available", 32'(exp_q.size() > 0), 32'h1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.care) chk("read_byte", 32'(mon_acc), 32'(mon_e.v));
                end
            end
        end
    end

    task automatic beat(input logic [3:0] d);
        din = d;
        #HALF;
        sck = 1'b1;
        #HALF;
        sck = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit quad);
        if (quad) begin
            beat(b[7:4]);
            beat(b[3:0]);
        end else begin
            for (int i = 7; i >= 0; i--) beat({3'($urandom), b[i]});
        end
    endtask

    task automatic send_addr(input logic [23:0] a, input bit quad);
        if (quad) begin
            for (int i = 5; i >= 0; i--) beat(a[i*4 +: 4]);
        end else begin
            for (int i = 23; i >= 0; i--) beat({3'($urandom), a[i]});
        end
    endtask

    task automatic cs_begin();
        ce_n = 1'b0;
        #20;
    endtask

    task automatic cs_end();
        #HALF;
        ce_n = 1'b1;
        #(2*HALF);
    endtask

    task automatic do_write(input logic [7:0] cmd, input logic [23:0] a24, input int n,
                            input logic [31:0] data);
        bit         quad;
        int         a;
        logic [7:0] b;
        quad = m_qpi || (cmd == 8'h38);
        a    = int'(a24[MEM_AW-1:0]);
        cs_begin();
        send_byte(cmd, m_qpi);
        send_addr(a24, quad);
        for (int k = 0; k < n; k++) begin
            b = data[31 - 8*k -: 8];
            send_byte(b, quad);
            m_mem[a]   = b;
            m_known[a] = 1'b1;
            a = (a + 1) % DEPTH;
        end
        cs_end();
        chk("qpi_after_write", 32'(qpi_mode), 32'(m_qpi));
    endtask

    task automatic do_read(input logic [7:0] cmd, input logic [23:0] a24, input int n);
        bit   quad;
        int   a;
        exp_t e;
        quad = m_qpi || (cmd == 8'hEB);
        a    = int'(a24[MEM_AW-1:0]);
        cs_begin();
        send_byte(cmd, m_qpi);
        send_addr(a24, quad);
        if (quad) repeat (WAIT_CYCLES) beat(4'($urandom));
        for (int k = 0; k < n; k++) begin
            e.v    = m_mem[a];
            e.care = m_known[a];
            exp_q.push_back(e);
            a = (a + 1) % DEPTH;
        end
        rd_phase = quad ? 2 : 1;
        repeat (n * (quad ? 2 : 8)) beat(4'h0);
        rd_phase = 0;
        cs_end();
        chk("qpi_after_read", 32'(qpi_mode), 32'(m_qpi));
    endtask

    // mode and unknown commands: only 0x35/0xF5 can change the mode, and re-entering is a no-op
    task automatic do_mode(input logic [7:0] cmd, input int extra);
        cs_begin();
        send_byte(cmd, m_qpi);
        repeat (extra) beat(4'($urandom));
        cs_end();
        if (cmd == 8'h35) m_qpi = 1'b1;
        else if (cmd == 8'hF5) m_qpi = 1'b0;
        chk("qpi_mode", 32'(qpi_mode), 32'(m_qpi));
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int          op;
        int          n;
        logic [23:0] ra;
        logic [7:0]  jc;
        exp_t        e;

        HRESETn = 1'b0;
        sck     = 1'b0;
        ce_n    = 1'b1;
        din     = 4'h0;
        repeat (3) @(negedge HCLK);
        chk("reset_douten", 32'(douten), 32'h0);
        chk("reset_dout", 32'(dout), 32'h0);
        chk("reset_qpi", 32'(qpi_mode), 32'h0);
        HRESETn = 1'b1;
        #20;

        // serial write then serial read
        do_write(8'h02, 24'h000010, 2, 32'hA53C_0000);
        do_read (8'h03, 24'h000010, 2);

        // quad write across the top of memory, wrap to 0
        do_write(8'h38, 24'h0003FF, 2, 32'h1122_0000);
        do_read (8'hEB, 24'h0003FF, 2);
        do_read (8'h03, 24'h000000, 1);

        // exit in SPI mode is ignored; enter, re-enter, quad-mapped commands, exit
        do_mode (8'hF5, 0);
        do_mode (8'h35, 0);
        do_mode (8'h35, 2);
        do_read (8'h03, 24'h000010, 1);
        do_write(8'h02, 24'h000040, 3, 32'hDEAD_BE00);
        do_read (8'hEB, 24'h000040, 3);
        do_mode (8'hF5, 3);

        // partial trailing byte must be discarded
        do_write(8'h02, 24'h000021, 1, 32'h5A00_0000);
        cs_begin();
        send_byte(8'h02, 1'b0);
        send_addr(24'h000020, 1'b0);
        send_byte(8'hFF, 1'b0);
        repeat (4) beat(4'($urandom));
        cs_end();
        m_mem[32'h20]   = 8'hFF;
        m_known[32'h20] = 1'b1;
        do_read (8'h03, 24'h000020, 2);

        // unsupported command keeps the bus quiet, next command is unaffected
        do_mode (8'h9F, 32);
        do_read (8'h03, 24'h000010, 2);

        for (int t = 0; t < 25; t++) begin
            op = $urandom_range(0, 5);
            n  = $urandom_range(1, 4);
            ra = {14'($urandom), 10'((DEPTH - 8 + $urandom_range(0, 15)) % DEPTH)};
            case (op)
                0: do_write(8'h02, ra, n, $urandom);
                1: do_write(8'h38, ra, n, $urandom);
                2: do_read (8'h03, ra, n);
                3: do_read (8'hEB, ra, n);
                4: do_mode ($urandom_range(0, 1) ? 8'h35 : 8'hF5, $urandom_range(0, 3));
                default: begin
                    do jc = 8'($urandom);
                    while (jc inside {8'h03, 8'h02, 8'hEB, 8'h38, 8'h35, 8'hF5});
                    do_mode(jc, 8);
                end
            endcase
        end

        // reset in the middle of a quad read
        do_mode(8'h35, 0);
        cs_begin();
        send_byte(8'h03, 1'b1);
        send_addr(24'h000010, 1'b1);
        repeat (WAIT_CYCLES) beat(4'($urandom));
        e.v    = m_mem[32'h10];
        e.care = m_known[32'h10];
        exp_q.push_back(e);
        rd_phase = 2;
        beat(4'h0);
        beat(4'h0);
        rd_phase = 0;
        #50;
        chk("douten_before_reset", 32'(douten), 32'hF);
        HRESETn = 1'b0;
        m_qpi   = 1'b0;
        #10;
        chk("douten_in_reset", 32'(douten), 32'h0);
        chk("dout_in_reset", 32'(dout), 32'h0);
        chk("qpi_in_reset", 32'(qpi_mode), 32'h0);
        #100;
        HRESETn = 1'b1;
        #20;
        // ce_n still low at release: a valid read pattern must not start anything
        send_byte(8'h03, 1'b0);
        send_addr(24'h000010, 1'b0);
        repeat (8) beat(4'h0);
        cs_end();
        chk("qpi_after_reset", 32'(qpi_mode), 32'h0);
        do_read(8'h03, 24'h000010, 2);

        #200;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
